// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH entries of {pc, ir}, flushable.
// Define FETCH_QUEUE_BYPASS_EN to forward an empty-queue push to decode in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [WIDTH-1:0]       in_ir,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_pc,
  output logic [WIDTH-1:0]       out_ir,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic [WIDTH-1:0] ir_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = cnt_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_ir    = '0;
    if (flush) begin
      out_valid = 1'b0;
    end else if (!empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[rd_ptr];
      out_ir    = ir_mem[rd_ptr];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_ir    = in_ir;
    end
  end

  // A bypassed entry taken by decode is never written to storage.
  assign push = in_valid && in_ready && !flush
              && !(bypass && out_ready);
  assign pop  = out_valid && out_ready && !flush && !bypass;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr] <= in_pc;
      ir_mem[wr_ptr] <= in_ir;
    end
  end

endmodule
